// File: rtl/decode_stage_pipe_if.sv
// Handshake bundle for decode_stage_pipe: upstream instruction side and
// downstream decoded-field side, seen from the producer/consumer (master) or the stage (slave).
interface decode_stage_pipe_if #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 3,
  parameter int JMP_W   = 9,
  parameter int DATA_W  = 16,
  parameter int PC_W    = 9
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc;
  logic               out_valid;
  logic               out_ready;
  logic [OPC_W-1:0]   out_opcode;
  logic [REG_W-1:0]   out_rd;
  logic [REG_W-1:0]   out_rs1;
  logic [REG_W-1:0]   out_rs2;
  logic [DATA_W-1:0]  out_imm;
  logic [JMP_W-1:0]   out_jmp;
  logic [PC_W-1:0]    out_pc;
  logic               out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm, out_jmp, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2,
           out_imm, out_jmp, out_pc, out_illegal
  );
endinterface

// File: rtl/decode_stage_pipe.sv
// Registered instruction-decode stage with a 2-entry skid buffer (main + skid).
// Macro DECODE_IMM_SEXT_EN selects sign extension of the immediate (default: zero extension).
module decode_stage_pipe #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 3,
  parameter int IMM_W   = 6,
  parameter int JMP_W   = 9,
  parameter int DATA_W  = 16,
  parameter int PC_W    = 9,
  parameter logic [(2**OPC_W)-1:0] OPC_LEGAL_MASK = {(2**OPC_W){1'b1}}
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  decode_stage_pipe_if.slave bus
);

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic [JMP_W-1:0]  jmp;
    logic [PC_W-1:0]   pc;
    logic              illegal;
  } entry_t;

  // State encoding doubles as {main_valid, skid_valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t state_r;
  state_t state_nxt_s;
  logic   out_valid_r;
  logic   in_ready_r;
  entry_t main_r;
  entry_t skid_r;
  entry_t decoded_s;
  logic   in_fire_s;
  logic   out_fire_s;
  logic   load_main_in_s;
  logic   load_main_skid_s;
  logic   load_skid_s;

  // Each field is cut independently, so overlapping fields are allowed.
  function automatic entry_t decode_instr(input logic [INSTR_W-1:0] instr,
                                          input logic [PC_W-1:0]    pc);
    entry_t            e_s;
    logic [IMM_W-1:0]  imm_s;
    imm_s     = instr[INSTR_W-1 -: IMM_W];
    e_s.opcode = instr[OPC_W-1:0];
    e_s.rd     = instr[OPC_W +: REG_W];
    e_s.rs1    = instr[OPC_W+REG_W +: REG_W];
    e_s.rs2    = instr[OPC_W+2*REG_W +: REG_W];
`ifdef DECODE_IMM_SEXT_EN
    e_s.imm    = DATA_W'($signed(imm_s));
`else
    e_s.imm    = DATA_W'(imm_s);
`endif
    e_s.jmp     = instr[OPC_W +: JMP_W];
    e_s.pc      = pc;
    e_s.illegal = ~OPC_LEGAL_MASK[instr[OPC_W-1:0]];
    return e_s;
  endfunction

  assign decoded_s  = decode_instr(bus.in_instr, bus.in_pc);
  assign in_fire_s  = bus.in_valid && in_ready_r;
  assign out_fire_s = out_valid_r && bus.out_ready;

  // Next-state and load-select logic for the main/skid pair; flush wins over any transfer.
  always_comb begin
    state_nxt_s      = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_nxt_s = ST_EMPTY;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (in_fire_s) begin
            load_main_in_s = 1'b1;
            state_nxt_s    = ST_ONE;
          end else begin
            state_nxt_s = ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (in_fire_s && out_fire_s) begin
            load_main_in_s = 1'b1;
            state_nxt_s    = ST_ONE;
          end else if (in_fire_s) begin
            load_skid_s = 1'b1;
            state_nxt_s = ST_FULL;
          end else if (out_fire_s) begin
            state_nxt_s = ST_EMPTY;
          end else begin
            state_nxt_s = ST_ONE;
          end
        end
        ST_FULL: begin
          if (out_fire_s) begin
            load_main_skid_s = 1'b1;
            state_nxt_s      = ST_ONE;
          end else begin
            state_nxt_s = ST_FULL;
          end
        end
        default: begin
          state_nxt_s = ST_EMPTY;
        end
      endcase
    end
  end

  // State register; valid/ready are mirrored into their own flops so no port is combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_EMPTY;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      out_valid_r <= state_nxt_s[1];
      in_ready_r  <= ~state_nxt_s[0];
    end
  end

  // Data registers; flush leaves contents alone since valid already masks them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      if (load_main_in_s) begin
        main_r <= decoded_s;
      end else if (load_main_skid_s) begin
        main_r <= skid_r;
      end else begin
        main_r <= main_r;
      end
      if (load_skid_s) begin
        skid_r <= decoded_s;
      end else begin
        skid_r <= skid_r;
      end
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_opcode  = main_r.opcode;
  assign bus.out_rd      = main_r.rd;
  assign bus.out_rs1     = main_r.rs1;
  assign bus.out_rs2     = main_r.rs2;
  assign bus.out_imm     = main_r.imm;
  assign bus.out_jmp     = main_r.jmp;
  assign bus.out_pc      = main_r.pc;
  assign bus.out_illegal = main_r.illegal;

endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe (legal mask 16'h00FF) with a short
// random-handshake phase checked against a FIFO scoreboard.
module tb_decode_stage_pipe;
  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  decode_stage_pipe_if #(.INSTR_W(16), .OPC_W(4), .REG_W(3), .JMP_W(9),
                         .DATA_W(16), .PC_W(9)) bus ();

  decode_stage_pipe #(
    .INSTR_W(16), .OPC_W(4), .REG_W(3), .IMM_W(6), .JMP_W(9),
    .DATA_W(16), .PC_W(9), .OPC_LEGAL_MASK(16'h00FF)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: fields cut by hand for the default geometry, opcodes >= 8 illegal.
  function automatic logic [47:0] exp_beat(input logic [15:0] i, input logic [8:0] pc);
    logic [15:0] imm;
`ifdef DECODE_IMM_SEXT_EN
    imm = {{10{i[15]}}, i[15:10]};
`else
    imm = {10'd0, i[15:10]};
`endif
    return {i[3:0], i[6:4], i[9:7], i[12:10], imm, i[12:4], pc, (i[3:0] >= 4'd8)};
  endfunction

  function automatic logic [47:0] obs_beat();
    return {bus.out_opcode, bus.out_rd, bus.out_rs1, bus.out_rs2, bus.out_imm,
            bus.out_jmp, bus.out_pc, bus.out_illegal};
  endfunction

  logic [15:0] q_instr[$];
  logic [8:0]  q_pc[$];
  logic [15:0] pop_instr;
  logic [8:0]  pop_pc;
  logic [8:0]  seq;

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0000;
    bus.in_pc     = 9'h000;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_data", obs_beat(), 48'h0);
    rst_n = 1'b1;
    tick();

    // Single beat through an empty stage
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'hA5B3;
    bus.in_pc     = 9'h010;
    tick();
    bus.in_valid = 1'b0;
    check("t1_valid", bus.out_valid, 1'b1);
    check("t1_opcode", bus.out_opcode, 4'h3);
    check("t1_rd", bus.out_rd, 3'd3);
    check("t1_rs1", bus.out_rs1, 3'd3);
    check("t1_rs2", bus.out_rs2, 3'd1);
    check("t1_jmp", bus.out_jmp, 9'h05B);
    check("t1_pc", bus.out_pc, 9'h010);
    check("t1_illegal", bus.out_illegal, 1'b0);
`ifdef DECODE_IMM_SEXT_EN
    check("t2_imm", bus.out_imm, 16'hFFE9);
`else
    check("t2_imm", bus.out_imm, 16'h0029);
`endif
    tick();
    check("t1_drained", bus.out_valid, 1'b0);

    // Backpressure: two accepted, third held upstream
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h0001;
    bus.in_pc     = 9'h001;
    tick();
    check("t3_one_valid", bus.out_valid, 1'b1);
    check("t3_one_ready", bus.in_ready, 1'b1);
    bus.in_instr = 16'h0002;
    bus.in_pc    = 9'h002;
    tick();
    check("t3_full_ready", bus.in_ready, 1'b0);
    check("t3_full_opc", bus.out_opcode, 4'h1);
    bus.in_instr = 16'h0003;
    bus.in_pc    = 9'h003;
    tick();
    check("t3_hold_ready", bus.in_ready, 1'b0);
    check("t3_hold_stable", {bus.out_opcode, bus.out_pc}, {4'h1, 9'h001});
    bus.out_ready = 1'b1;
    tick();
    check("t3_out2", {bus.out_valid, bus.out_opcode, bus.out_pc}, {1'b1, 4'h2, 9'h002});
    check("t3_ready_back", bus.in_ready, 1'b1);
    tick();
    bus.in_valid = 1'b0;
    check("t3_out3", {bus.out_valid, bus.out_opcode, bus.out_pc}, {1'b1, 4'h3, 9'h003});
    tick();
    check("t3_empty", bus.out_valid, 1'b0);

    // Flush while FULL with a third instruction offered
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h0011;
    bus.in_pc     = 9'h011;
    tick();
    bus.in_instr = 16'h0012;
    bus.in_pc    = 9'h012;
    tick();
    bus.in_instr = 16'h0013;
    bus.in_pc    = 9'h013;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_flush_valid", bus.out_valid, 1'b0);
    check("t5_flush_ready", bus.in_ready, 1'b1);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t5_nothing_left", bus.out_valid, 1'b0);
    end

    // Flush in ONE discards an offered (acceptable) input
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h0021;
    bus.in_pc     = 9'h021;
    tick();
    bus.in_instr = 16'h0022;
    bus.in_pc    = 9'h022;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    check("t5_flush_one", bus.out_valid, 1'b0);
    bus.out_ready = 1'b1;
    tick();
    check("t5_flush_one_after", bus.out_valid, 1'b0);

    // Legality against mask 16'h00FF
    bus.in_valid = 1'b1;
    bus.in_instr = 16'h000C;
    bus.in_pc    = 9'h031;
    tick();
    bus.in_instr = 16'h0007;
    bus.in_pc    = 9'h032;
    check("t6_illegal_c", {bus.out_valid, bus.out_pc, bus.out_illegal}, {1'b1, 9'h031, 1'b1});
    tick();
    bus.in_valid = 1'b0;
    check("t6_legal_7", {bus.out_valid, bus.out_pc, bus.out_illegal}, {1'b1, 9'h032, 1'b0});
    tick();

    // Random handshake against the scoreboard
    seq = 9'h100;
    for (int c = 0; c < 400; c++) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_instr  = 16'($urandom);
      bus.in_pc     = seq;
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (bus.out_valid && bus.out_ready) begin
        if (q_instr.size() == 0) begin
          check("t4_unexpected_beat", 1'b1, 1'b0);
        end else begin
          pop_instr = q_instr.pop_front();
          pop_pc    = q_pc.pop_front();
          check("t4_beat", obs_beat(), exp_beat(pop_instr, pop_pc));
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q_instr.push_back(bus.in_instr);
        q_pc.push_back(seq);
        seq = seq + 9'd1;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (bus.out_valid) begin
        if (q_instr.size() == 0) begin
          check("t4_drain_extra", 1'b1, 1'b0);
        end else begin
          pop_instr = q_instr.pop_front();
          pop_pc    = q_pc.pop_front();
          check("t4_drain_beat", obs_beat(), exp_beat(pop_instr, pop_pc));
        end
      end
      tick();
    end
    check("t4_queue_empty", q_instr.size(), 0);
    check("t4_idle", bus.out_valid, 1'b0);

    // Asynchronous reset while FULL
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = 16'h0041;
    bus.in_pc     = 9'h041;
    tick();
    bus.in_instr = 16'h0042;
    bus.in_pc    = 9'h042;
    tick();
    bus.in_valid = 1'b0;
    check("t6_full_before_rst", {bus.out_valid, bus.in_ready}, {1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_valid", bus.out_valid, 1'b0);
    check("t6_async_ready", bus.in_ready, 1'b1);
    check("t6_async_data", obs_beat(), 48'h0);
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    check("t6_post_rst_idle", bus.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
